branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch resolver. It adds a direct-mapped branch target buffer with 2-bit saturating direction counters, which gives the IF stage a same-cycle taken/target prediction. It also resolves branches, JAL and JALR in EX against that prediction and raises redirect/flush only on misprediction. The block carries saturating performance counters for resolved control-flow instructions and for mispredictions.

Parameters:
XLEN, 32, datapath/PC width
ENTRIES, 64, BTB entries; power of two, minimum 2
IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2]
TAG_W, XLEN-IDX_W-2, tag width; tag = pc[XLEN-1:IDX_W+2]
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_pc  in  XLEN  PC being fetched
if_pred_taken  out  1  prediction: redirect fetch
if_pred_target  out  XLEN  predicted target
ex_valid  in  1  EX slot holds a live instruction
ex_pc  in  XLEN  PC of the EX instruction
ex_funct3  in  3  branch condition code
ex_rs1_data  in  XLEN  forwarded rs1
ex_rs2_data  in  XLEN  forwarded rs2
ex_immediate  in  XLEN  sign-extended immediate
ex_is_branch  in  1  conditional branch
ex_is_jal  in  1  JAL
ex_is_jalr  in  1  JALR
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_target  in  XLEN  predicted target carried down the pipe
ex_redirect  out  1  mispredict: load ex_redirect_pc into PC
ex_redirect_pc  out  XLEN  corrected PC
ex_flush  out  1  flush IF/ID and ID/EX
stat_ctrl_count  out  CNT_W  resolved control-flow instructions
stat_miss_count  out  CNT_W  mispredictions

Behaviour:
- Clocking: single clock, clk; reset rst is synchronous and active-high.
- Reset: all entry valid bits and tags cleared. All counters set to 2'b01 (weakly not-taken). Both stats cleared to 0.
- Outputs while rst=1: if_pred_taken=0, if_pred_target=0, ex_redirect=0, ex_redirect_pc=0, ex_flush=0.
- Lookup is combinational from registered storage, with 0-cycle latency:
  - hit = valid[idx] && tag[idx]==if_tag.
  - if_pred_taken = hit && cnt[idx][1].
  - if_pred_target = hit ? target[idx] : if_pc+4.
- Resolution is combinational in EX:
  - Branch taken: BRANCH_EQ/NE/LT/GE/LTU/GEU; LT/GE are signed, LTU/GEU unsigned. Any other funct3 means not taken.
  - JAL and JALR are always taken.
  - Branch/JAL target = ex_pc+ex_immediate.
  - JALR target = (ex_rs1_data+ex_immediate) & ~1.
  - All arithmetic is modulo 2^XLEN (wrap-around, no overflow detection).
- Mispredict, evaluated only when ex_valid and the instruction is control flow:
  - actual taken and (!ex_pred_taken or ex_pred_target != target): redirect to target.
  - actual not taken and ex_pred_taken: redirect to ex_pc+4.
  - ex_flush = ex_redirect. Otherwise both are 0 and ex_redirect_pc = 0.
- Priority: if more than one of is_branch/is_jal/is_jalr is asserted, the order is jalr > jal > branch.
- Update at the clk edge when ex_valid and the instruction is control flow, with idx/tag taken from ex_pc:
  - Entry hit: counter +1 (saturating at 3) if taken, -1 (saturating at 0) if not taken. If taken, target is rewritten.
  - Entry miss, taken: allocate; set valid, write tag and target. Counter = 2'b10 for a branch, 2'b11 for JAL/JALR.
  - Entry miss, not taken: no write.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass).
- Stats at the same edge:
  - stat_ctrl_count +1 per resolved control-flow instruction.
  - stat_miss_count +1 per redirect.
  - Both saturate at 2^CNT_W-1.
- ex_valid=0: no update, no redirect, no stat change.
- rst asserted mid-stream overrides any update in that cycle.

Decomposition:
- Shared constants file: existing BRANCH_* funct3 codes, plus new BP_SNT/BP_WNT/BP_WT/BP_ST counter encodings and BP_INIT=BP_WNT.
- One natural sub-module: branch_compare (combinational funct3 condition evaluation, XLEN-parametrised), instantiated once.
- BTB arrays and stat counters stay in the top module.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104. Both stats read 0.
- BEQ at 0x100, rs1=rs2=5, imm=0x40, pred_taken=0 -> ex_redirect=1, redirect_pc=0x140, flush=1. Next cycle, lookup of 0x100 gives taken, target 0x140. Both stats read 1.
- Same BEQ resolved again with rs1=5, rs2=6, pred_taken=1, pred_target=0x140 -> redirect to 0x104; counter 10->01, so the next lookup gives not taken.
- Four taken resolutions of BLT at 0x200 with rs1=0xFFFFFFFF, rs2=1 (signed taken), then one not-taken -> counter saturates at 11 and then reaches 10; prediction stays taken. BLTU with the same operands resolves not taken.
- JALR at 0x300, rs1=0x1001, imm=0x10, pred_target=0x1010 -> no redirect (target 0x1010, bit 0 cleared). With pred_target=0x2000 -> redirect to 0x1010.
- Alias: entries at 0x100 and 0x100+4*ENTRIES -> the second allocation replaces the tag; lookup of 0x100 misses. Also: assert rst during a mispredicting EX cycle -> no redirect, table empty after.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// ============================================================================
// Module  : branch_predict_unit_pkg
// Purpose : Shared constants for the branch predict unit. Holds the RV32
//           branch funct3 codes and the 2-bit direction counter encodings.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predict_unit_pkg;

    // Branch condition codes (funct3 of the B-type encoding)
    localparam logic [2:0] BRANCH_EQ  = 3'b000;
    localparam logic [2:0] BRANCH_NE  = 3'b001;
    localparam logic [2:0] BRANCH_LT  = 3'b100;
    localparam logic [2:0] BRANCH_GE  = 3'b101;
    localparam logic [2:0] BRANCH_LTU = 3'b110;
    localparam logic [2:0] BRANCH_GEU = 3'b111;

    // 2-bit saturating direction counter; bit 1 is the taken prediction
    localparam logic [1:0] BP_SNT  = 2'b00;
    localparam logic [1:0] BP_WNT  = 2'b01;
    localparam logic [1:0] BP_WT   = 2'b10;
    localparam logic [1:0] BP_ST   = 2'b11;
    localparam logic [1:0] BP_INIT = BP_WNT;

endpackage

`default_nettype wire

// File: rtl/branch_predict_unit_compare.sv
// ============================================================================
// Module  : branch_compare
// Purpose : Combinational evaluation of a conditional-branch condition.
// Ports   : funct3 - condition code
//           a, b   - operands (rs1, rs2)
//           taken  - condition holds; unknown codes give 0
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            BRANCH_EQ:  taken = (a == b);
            BRANCH_NE:  taken = (a != b);
            BRANCH_LT:  taken = ($signed(a) <  $signed(b));
            BRANCH_GE:  taken = ($signed(a) >= $signed(b));
            BRANCH_LTU: taken = (a <  b);
            BRANCH_GEU: taken = (a >= b);
            default:    taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module  : branch_predict_unit
// Purpose : Direct-mapped BTB with 2-bit direction counters giving a
//           same-cycle fetch prediction, plus EX-stage resolution of
//           branch/JAL/JALR that redirects only on misprediction, and
//           saturating counters of resolved and mispredicted instructions.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           if_pc / if_pred_*        - fetch lookup and prediction
//           ex_*  (inputs)           - instruction being resolved in EX
//           ex_redirect/_pc/ex_flush - misprediction recovery
//           stat_ctrl/miss_count     - performance counters
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = XLEN - IDX_W - 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [XLEN-1:0]  if_pred_target,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1_data,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic [XLEN-1:0]  ex_immediate,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             ex_redirect,
    output logic [XLEN-1:0]  ex_redirect_pc,
    output logic             ex_flush,
    output logic [CNT_W-1:0] stat_ctrl_count,
    output logic [CNT_W-1:0] stat_miss_count
);

    localparam logic [XLEN-1:0] C_FOUR = XLEN'(4);

    // BTB storage
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic [1:0]       r_cnt    [ENTRIES];

    // ---------------- Fetch lookup ----------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign if_pred_taken  = !rst && w_if_hit && r_cnt[w_if_idx][1];
    assign if_pred_target = rst      ? '0 :
                            w_if_hit ? r_target[w_if_idx] : (if_pc + C_FOUR);

    // ---------------- EX resolution ----------------
    logic             w_br_cond;
    logic             w_is_ctrl;
    logic             w_is_jump;
    logic             w_resolve;
    logic             w_act_taken;
    logic [XLEN-1:0]  w_act_target;
    logic             w_mispred;

    branch_compare #(.XLEN(XLEN)) u_branch_compare (
        .funct3 (ex_funct3),
        .a      (ex_rs1_data),
        .b      (ex_rs2_data),
        .taken  (w_br_cond)
    );

    assign w_is_jump = ex_is_jal || ex_is_jalr;
    assign w_is_ctrl = w_is_jump || ex_is_branch;
    assign w_resolve = ex_valid && w_is_ctrl;

    // Jumps dominate the branch condition, so a jump flag always means taken
    assign w_act_taken  = w_is_jump || w_br_cond;
    assign w_act_target = ex_is_jalr ? ((ex_rs1_data + ex_immediate) & ~C_FOUR[XLEN-1:0] & ~XLEN'(1)) | ((ex_rs1_data + ex_immediate) & C_FOUR)
                                     : (ex_pc + ex_immediate);

    assign w_mispred = w_resolve &&
                       (w_act_taken ? (!ex_pred_taken || (ex_pred_target != w_act_target))
                                    : ex_pred_taken);

    assign ex_redirect    = !rst && w_mispred;
    assign ex_flush       = ex_redirect;
    assign ex_redirect_pc = !ex_redirect ? '0 :
                            w_act_taken  ? w_act_target : (ex_pc + C_FOUR);

    // ---------------- Update ----------------
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= BP_INIT;
            end
            stat_ctrl_count <= '0;
            stat_miss_count <= '0;
        end else if (w_resolve) begin
            if (w_ex_hit) begin
                if (w_act_taken) begin
                    if (r_cnt[w_ex_idx] != BP_ST)
                        r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
                    r_target[w_ex_idx] <= w_act_target;
                end else if (r_cnt[w_ex_idx] != BP_SNT) begin
                    r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
                end
            end else if (w_act_taken) begin
                // Allocation: jumps start strongly taken, branches weakly taken
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= w_act_target;
                r_cnt[w_ex_idx]    <= w_is_jump ? BP_ST : BP_WT;
            end

            if (stat_ctrl_count != '1)
                stat_ctrl_count <= stat_ctrl_count + CNT_W'(1);
            if (w_mispred && (stat_miss_count != '1))
                stat_miss_count <= stat_miss_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none

module tb_branch_predict_unit;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'h0;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_rs1_data = 32'h0;
    logic [31:0] ex_rs2_data = 32'h0;
    logic [31:0] ex_immediate = 32'h0;
    logic        ex_is_branch = 1'b0;
    logic        ex_is_jal = 1'b0;
    logic        ex_is_jalr = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'h0;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_flush;
    logic [31:0] stat_ctrl_count;
    logic [31:0] stat_miss_count;

    int checks = 0;
    int failures = 0;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_funct3(ex_funct3),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_immediate(ex_immediate), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
        .ex_flush(ex_flush), .stat_ctrl_count(stat_ctrl_count),
        .stat_miss_count(stat_miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    bit          m_valid [N];
    int unsigned m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_cnt   [N];
    int unsigned m_ctrl = 0;
    int unsigned m_miss = 0;

    function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        int          li, ei;
        bit          lhit, ehit, ctrl, tk, mp;
        logic [31:0] tg;
        logic        e_ptk;
        logic [31:0] e_ptg, e_rpc;

        li   = (if_pc / 4) % N;
        lhit = m_valid[li] && (m_tag[li] == if_pc / (4 * N));
        e_ptk = !rst && lhit && (m_cnt[li] >= 2);
        e_ptg = rst ? 32'h0 : (lhit ? m_tgt[li] : if_pc + 32'd4);

        ctrl = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
        if (ex_is_jalr)     begin tk = 1; tg = (ex_rs1_data + ex_immediate) & 32'hFFFF_FFFE; end
        else if (ex_is_jal) begin tk = 1; tg = ex_pc + ex_immediate; end
        else                begin tk = cond(ex_funct3, ex_rs1_data, ex_rs2_data); tg = ex_pc + ex_immediate; end
        mp = ctrl && (tk ? (!ex_pred_taken || ex_pred_target != tg) : ex_pred_taken);
        e_rpc = (!rst && mp) ? (tk ? tg : ex_pc + 32'd4) : 32'h0;

        chk("m_if_pred_taken",  {31'd0, if_pred_taken}, {31'd0, e_ptk});
        chk("m_if_pred_target", if_pred_target, e_ptg);
        chk("m_ex_redirect",    {31'd0, ex_redirect}, {31'd0, !rst && mp});
        chk("m_ex_flush",       {31'd0, ex_flush},    {31'd0, !rst && mp});
        chk("m_ex_redirect_pc", ex_redirect_pc, e_rpc);
        chk("m_stat_ctrl",      stat_ctrl_count, m_ctrl);
        chk("m_stat_miss",      stat_miss_count, m_miss);

        // Advance the model to the state the coming edge produces
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
            end
            m_ctrl = 0; m_miss = 0;
        end else if (ctrl) begin
            ei   = (ex_pc / 4) % N;
            ehit = m_valid[ei] && (m_tag[ei] == ex_pc / (4 * N));
            if (ehit) begin
                if (tk) begin
                    m_cnt[ei] = (m_cnt[ei] == 3) ? 3 : m_cnt[ei] + 1;
                    m_tgt[ei] = tg;
                end else begin
                    m_cnt[ei] = (m_cnt[ei] == 0) ? 0 : m_cnt[ei] - 1;
                end
            end else if (tk) begin
                m_valid[ei] = 1;
                m_tag[ei]   = ex_pc / (4 * N);
                m_tgt[ei]   = tg;
                m_cnt[ei]   = (ex_is_jal || ex_is_jalr) ? 3 : 2;
            end
            m_ctrl++;
            if (mp) m_miss++;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic idle(input logic [31:0] pc);
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_pred_taken = 0; ex_pred_target = 0;
        if_pc = pc;
    endtask

    task automatic op(input logic [31:0] pc, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic br, input logic jal, input logic jalr,
                      input logic ptk, input logic [31:0] ptg);
        ex_valid = 1; ex_pc = pc; ex_funct3 = f3; ex_rs1_data = a; ex_rs2_data = b;
        ex_immediate = imm; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_pred_taken = ptk; ex_pred_target = ptg;
        if_pc = pc;
    endtask

    // Wait to mid-cycle so literal checks see settled combinational outputs
    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if_pc = 32'h100;
        repeat (2) nxt();
        rst = 0;
        idle(32'h100);
        mid();
        chk("rst_pred_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("rst_pred_target", if_pred_target, 32'h104);
        chk("rst_stat_ctrl", stat_ctrl_count, 32'd0);
        chk("rst_stat_miss", stat_miss_count, 32'd0);
        nxt();

        // BEQ taken, predicted not taken
        op(32'h100, 3'd0, 5, 5, 32'h40, 1, 0, 0, 0, 0);
        mid();
        chk("beq_redirect", {31'd0, ex_redirect}, 32'd1);
        chk("beq_redirect_pc", ex_redirect_pc, 32'h140);
        chk("beq_flush", {31'd0, ex_flush}, 32'd1);
        nxt();
        idle(32'h100);
        mid();
        chk("beq_lookup_taken", {31'd0, if_pred_taken}, 32'd1);
        chk("beq_lookup_target", if_pred_target, 32'h140);
        chk("beq_stat_ctrl", stat_ctrl_count, 32'd1);
        chk("beq_stat_miss", stat_miss_count, 32'd1);
        nxt();

        // Same BEQ, not taken but predicted taken
        op(32'h100, 3'd0, 5, 6, 32'h40, 1, 0, 0, 1, 32'h140);
        mid();
        chk("beq_nt_redirect_pc", ex_redirect_pc, 32'h104);
        nxt();
        idle(32'h100);
        mid();
        chk("beq_nt_lookup", {31'd0, if_pred_taken}, 32'd0);
        nxt();

        // BLT signed taken four times, then not taken
        op(32'h200, 3'd4, 32'hFFFF_FFFF, 1, 32'h20, 1, 0, 0, 0, 0);
        nxt();
        for (int k = 0; k < 3; k++) begin
            op(32'h200, 3'd4, 32'hFFFF_FFFF, 1, 32'h20, 1, 0, 0, 1, 32'h220);
            mid();
            chk("blt_no_redirect", {31'd0, ex_redirect}, 32'd0);
            nxt();
        end
        op(32'h200, 3'd5, 32'hFFFF_FFFF, 1, 32'h20, 1, 0, 0, 1, 32'h220);
        mid();
        chk("bge_nt_redirect_pc", ex_redirect_pc, 32'h204);
        nxt();
        idle(32'h200);
        mid();
        chk("blt_still_taken", {31'd0, if_pred_taken}, 32'd1);
        nxt();
        op(32'h200, 3'd6, 32'hFFFF_FFFF, 1, 32'h20, 1, 0, 0, 0, 0);
        mid();
        chk("bltu_not_taken", {31'd0, ex_redirect}, 32'd0);
        nxt();

        // JALR with bit 0 cleared
        op(32'h300, 3'd0, 32'h1001, 0, 32'h10, 0, 0, 1, 1, 32'h1010);
        mid();
        chk("jalr_ok", {31'd0, ex_redirect}, 32'd0);
        nxt();
        op(32'h300, 3'd0, 32'h1001, 0, 32'h10, 0, 0, 1, 1, 32'h2000);
        mid();
        chk("jalr_bad_target", ex_redirect_pc, 32'h1010);
        nxt();

        // JAL and JALR both set: JALR target wins
        op(32'h308, 3'd0, 32'h4000, 0, 32'h8, 0, 1, 1, 0, 0);
        mid();
        chk("prio_jalr", ex_redirect_pc, 32'h4008);
        nxt();

        // ex_valid low: nothing happens
        op(32'h400, 3'd0, 1, 1, 32'h40, 1, 0, 0, 0, 0);
        ex_valid = 0;
        mid();
        chk("invalid_no_redirect", {31'd0, ex_redirect}, 32'd0);
        nxt();

        // Aliasing
        op(32'h100, 3'd0, 0, 0, 32'h8, 0, 1, 0, 0, 0);
        nxt();
        idle(32'h100);
        mid();
        chk("alias_first_hit", if_pred_target, 32'h108);
        nxt();
        op(32'h100 + 4 * N, 3'd0, 0, 0, 32'h8, 0, 1, 0, 0, 0);
        nxt();
        idle(32'h100);
        mid();
        chk("alias_evicted_taken", {31'd0, if_pred_taken}, 32'd0);
        chk("alias_evicted_target", if_pred_target, 32'h104);
        nxt();

        // Reset during a mispredicting EX cycle
        op(32'h300, 3'd0, 7, 7, 32'h40, 1, 0, 0, 0, 0);
        rst = 1;
        mid();
        chk("rst_mid_redirect", {31'd0, ex_redirect}, 32'd0);
        chk("rst_mid_pc", ex_redirect_pc, 32'd0);
        chk("rst_mid_target", if_pred_target, 32'd0);
        nxt();
        rst = 0;
        idle(32'h300);
        mid();
        chk("rst_mid_empty", if_pred_target, 32'h304);
        chk("rst_mid_stats", stat_ctrl_count, 32'd0);
        nxt();
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
